// File: rtl/mux21_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready requesters,
// with bounded bursts and a single registered output stage. Optional per-requester
// beat counters are enabled by defining MUX21_ARB_STATS_EN.
module mux21_rr_arbiter #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_valid,
   input  logic [DW-1:0] req_data0,
   input  logic [DW-1:0] req_data1,
   output logic [1:0]    req_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [1:0]    gnt,
   output logic          sel
`ifdef MUX21_ARB_STATS_EN
   ,
   output logic [15:0]   beats0,
   output logic [15:0]   beats1
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_G0    = 2'd1;
   localparam logic [1:0] ST_G1    = 2'd2;
   localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

   logic [1:0]    state_q, state_d;
   logic          prio_q, prio_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;

   logic          free;
   logic          xfer;
   logic          cur;
   logic          own_valid;
   logic          oth_valid;
   logic [DW-1:0] mux_data;

   function automatic logic [1:0] grant_state(input logic idx);
      return idx ? ST_G1 : ST_G0;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Handshake side: only the granted requester can be accepted, and only when
   // the output register is empty or being drained this cycle.
   always_comb begin
      gnt       = {state_q == ST_G1, state_q == ST_G0};
      free      = !out_valid_q || out_ready;
      req_ready = gnt & {2{free}};
      xfer      = |(req_valid & req_ready);
      cur       = (state_q == ST_G1);
      own_valid = cur ? req_valid[1] : req_valid[0];
      oth_valid = cur ? req_valid[0] : req_valid[1];
      mux_data  = sel_q ? req_data1 : req_data0;
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid == 2'b11) begin
               state_d = grant_state(prio_q);
               sel_d   = prio_q;
            end else if (req_valid[0]) begin
               state_d = ST_G0;
               sel_d   = 1'b0;
            end else if (req_valid[1]) begin
               state_d = ST_G1;
               sel_d   = 1'b1;
            end
         end
         ST_G0, ST_G1: begin
            if (xfer) begin
               // Burst expiry hands over only if the other side is waiting.
               if (cnt_q == CNT_LAST) begin
                  cnt_d = 4'd0;
                  if (oth_valid) begin
                     state_d = grant_state(!cur);
                     sel_d   = !cur;
                     prio_d  = !cur;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (!own_valid) begin
               cnt_d  = 4'd0;
               prio_d = !cur;
               if (oth_valid) begin
                  state_d = grant_state(!cur);
                  sel_d   = !cur;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         prio_q      <= 1'b0;
         cnt_q       <= 4'd0;
         sel_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sel       = sel_q;

`ifdef MUX21_ARB_STATS_EN
   logic [15:0] beats0_q, beats0_d;
   logic [15:0] beats1_q, beats1_d;

   always_comb begin
      beats0_d = beats0_q;
      beats1_d = beats1_q;
      if (xfer && !cur) beats0_d = sat_inc(beats0_q);
      if (xfer && cur)  beats1_d = sat_inc(beats1_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beats0_q <= 16'd0;
         beats1_q <= 16'd0;
      end else begin
         beats0_q <= beats0_d;
         beats1_q <= beats1_d;
      end
   end

   assign beats0 = beats0_q;
   assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Bench for mux21_rr_arbiter: queue-fed requesters, a cycle-level reference model of
// the arbitration rules, and directed scenarios followed by a randomized phase.
module tb_mux21_rr_arbiter;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [DW-1:0] req_data0, req_data1;
   logic [1:0]    req_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [1:0]    gnt;
   logic          sel;
`ifdef MUX21_ARB_STATS_EN
   logic [15:0]   beats0, beats1;
`endif

   mux21_rr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .gnt(gnt), .sel(sel)
`ifdef MUX21_ARB_STATS_EN
      , .beats0(beats0), .beats1(beats1)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner -1 = nobody, run = beats in current burst.
   int          m_own, m_run, m_prio, m_sel, m_ov, m_b0, m_b1;
   logic [7:0]  m_od;
   logic [7:0]  q0[$], q1[$];
   bit          en0, en1;
   int          acc_log[$];
   logic [7:0]  out_log[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_own = -1; m_run = 0; m_prio = 0; m_sel = 0; m_ov = 0; m_od = 8'h00;
      m_b0 = 0; m_b1 = 0;
   endtask

   task automatic cycle();
      logic [1:0] g_e;
      bit         fr, acc;
      int         y;
      req_valid[0] = en0 && (q0.size() > 0);
      req_valid[1] = en1 && (q1.size() > 0);
      req_data0    = (q0.size() > 0) ? q0[0] : 8'h00;
      req_data1    = (q1.size() > 0) ? q1[0] : 8'h00;
      @(negedge clk);
      g_e = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
      fr  = (m_ov == 0) || out_ready;
      chk("gnt", gnt, g_e);
      chk("sel", sel, m_sel);
      chk("req_ready", req_ready, fr ? g_e : 2'b00);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
`ifdef MUX21_ARB_STATS_EN
      chk("beats0", beats0, m_b0);
      chk("beats1", beats1, m_b1);
`endif
      if ((req_valid & req_ready) == 2'b01) acc_log.push_back(0);
      if ((req_valid & req_ready) == 2'b10) acc_log.push_back(1);
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (rst) begin
         model_reset();
      end else begin
         acc = (m_own >= 0) && fr && req_valid[m_own];
         if (acc) begin
            m_ov = 1;
            if (m_own == 0) begin
               m_od = req_data0; void'(q0.pop_front());
               if (m_b0 < 65535) m_b0++;
            end else begin
               m_od = req_data1; void'(q1.pop_front());
               if (m_b1 < 65535) m_b1++;
            end
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (m_own < 0) begin
            if (req_valid == 2'b11) m_own = m_prio;
            else if (req_valid[0]) m_own = 0;
            else if (req_valid[1]) m_own = 1;
            if (m_own >= 0) m_sel = m_own;
         end else begin
            y = 1 - m_own;
            if (acc) begin
               m_run++;
               if (m_run == MB) begin
                  m_run = 0;
                  if (req_valid[y]) begin m_own = y; m_prio = y; m_sel = y; end
               end
            end else if (!req_valid[m_own]) begin
               m_run  = 0;
               m_prio = y;
               if (req_valid[y]) begin m_own = y; m_sel = y; end
               else m_own = -1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] exp_a[5];
      logic [7:0] exp_c[6];
      rst = 1'b1; out_ready = 1'b1; req_valid = 2'b00;
      req_data0 = 8'h00; req_data1 = 8'h00; en0 = 0; en1 = 0;
      @(posedge clk); #1;
      model_reset();
      cycle();
      rst = 1'b0;

      // Single requester: five back-to-back beats, grant held past burst expiry
      exp_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      foreach (exp_a[i]) q0.push_back(exp_a[i]);
      en0 = 1; out_log.delete();
      repeat (10) cycle();
      chk("single_count", out_log.size(), 5);
      foreach (exp_a[i]) if (i < out_log.size()) chk("single_data", out_log[i], exp_a[i]);

      // Reset in the middle of a burst
      repeat (4) q0.push_back(8'($urandom));
      repeat (3) cycle();
      rst = 1'b1; q0.delete();
      cycle();
      rst = 1'b0;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_out_valid", out_valid, 1'b0);

      // Contention: 4 from 0, 4 from 1, 4 from 0, no bubble
      repeat (8) begin q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); end
      en0 = 1; en1 = 1; acc_log.delete(); n = 0;
      while (acc_log.size() < 12 && n < 40) begin cycle(); n++; end
      chk("contention_cycles", n, 13);
      for (int i = 0; i < 12 && i < acc_log.size(); i++)
         chk("contention_order", acc_log[i], (i >= 4 && i < 8) ? 1 : 0);
`ifdef MUX21_ARB_STATS_EN
      chk("stats_b0", beats0, 16'd8);
      chk("stats_b1", beats1, 16'd4);
`endif
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 40) begin cycle(); n++; end
      repeat (3) cycle();

      // Backpressure during a G1 burst
      exp_c = '{8'h10, 8'h20, 8'hA5, 8'h30, 8'h40, 8'h50};
      foreach (exp_c[i]) q1.push_back(exp_c[i]);
      en0 = 0; en1 = 1; out_log.delete();
      repeat (4) cycle();
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      repeat (8) cycle();
      chk("bp_count", out_log.size(), 6);
      foreach (exp_c[i]) if (i < out_log.size()) chk("bp_data", out_log[i], exp_c[i]);

      // Early release: 0 gives up after one beat, grant moves to 1
      en0 = 1; en1 = 1;
      q0.push_back(8'h61); q1.push_back(8'h71); q1.push_back(8'h72);
      repeat (3) cycle();
      chk("release_gnt", gnt, 2'b10);
      repeat (6) cycle();
      // Both drop from G0 -> idle with priority on 1
      q0.push_back(8'h81);
      en1 = 0;
      repeat (4) cycle();
      en1 = 1;
      q0.push_back(8'h91); q1.push_back(8'h92);
      cycle();
      chk("prio_after_idle", gnt, 2'b10);
      repeat (8) cycle();

      // Randomized traffic with occasional reset
      en0 = 1; en1 = 1;
      repeat (600) begin
         if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(8'($urandom));
         if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(8'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 63) == 0);
         cycle();
      end
      rst = 1'b0; out_ready = 1'b1;

`ifdef MUX21_ARB_STATS_EN
      rst = 1'b1; q0.delete(); q1.delete();
      cycle();
      rst = 1'b0; en0 = 1; en1 = 0;
      repeat (65545) begin
         if (q0.size() < 2) q0.push_back(8'($urandom));
         cycle();
      end
      chk("stats_sat", beats0, 16'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
